// File: rtl/init_info_packer_pkg.sv
// Shared sizing helpers for the init-info packer: block size from the GF order,
// frame symbol count and a constant clog2.
package init_info_packer_pkg;

   function automatic int clog2_f(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits = bits + 1;
         rem  = rem >> 1;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

   function automatic int blk_size_f(input int gf_size_log2);
      return (1 << gf_size_log2) - 1;
   endfunction

   function automatic int frame_syms_f(input int pcm_coln, input int gf_size_log2);
      return pcm_coln * blk_size_f(gf_size_log2);
   endfunction

   localparam int DEF_INIT_INFO_WID = 2;
   localparam int DEF_GF_SIZE_LOG2  = 7;
   localparam int DEF_PCM_COLN      = 72;
   localparam int DEF_IN_SYMS       = 8;

endpackage

// File: rtl/init_info_packer_sym_accum.sv
// Symbol accumulator: appends input beats above the current fill and pops one
// block from the bottom; the block view already includes a beat arriving this cycle.
module init_info_packer_sym_accum
   import init_info_packer_pkg::*;
#(
   parameter int SYM_WID  = DEF_INIT_INFO_WID,
   parameter int BLK_SIZE = 127,
   parameter int IN_SYMS  = DEF_IN_SYMS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clr,
   input  logic                        push,
   input  logic                        pop,
   input  logic [IN_SYMS*SYM_WID-1:0]  data,
   output logic                        space,
   output logic                        avail,
   output logic [BLK_SIZE*SYM_WID-1:0] blk
);

   localparam int ACC_SYMS = BLK_SIZE + IN_SYMS - 1;
   localparam int ACC_W    = ACC_SYMS * SYM_WID;
   localparam int BLK_W    = BLK_SIZE * SYM_WID;
   localparam int FILL_W   = clog2_f(ACC_SYMS + 1);
   localparam logic [FILL_W-1:0] BLK_FILL = FILL_W'(BLK_SIZE);
   localparam logic [FILL_W-1:0] IN_FILL  = FILL_W'(IN_SYMS);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  comb;
   logic [ACC_W-1:0]  data_ext;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_sum;

   // Bits above fill are kept zero so a new beat can simply be OR-ed in.
   assign data_ext = ACC_W'(data);
   assign comb     = push ? (acc | (data_ext << (fill * SYM_WID))) : acc;
   assign fill_sum = push ? (fill + IN_FILL) : fill;
   assign space    = (fill < BLK_FILL);
   assign avail    = (fill_sum >= BLK_FILL);
   assign blk      = comb[BLK_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc  <= '0;
         fill <= '0;
      end else if (clr) begin
         acc  <= '0;
         fill <= '0;
      end else if (pop) begin
         acc  <= comb >> BLK_W;
         fill <= fill_sum - BLK_FILL;
      end else begin
         acc  <= comb;
         fill <= fill_sum;
      end
   end

endmodule

// File: rtl/init_info_packer.sv
// Packs narrow init-info symbol beats into full decoder blocks with a frame block
// counter. Define INIT_PACK_LEN_CHK_EN to check i_sym_last against the frame length.
module init_info_packer
   import init_info_packer_pkg::*;
#(
   parameter int INIT_INFO_WID = DEF_INIT_INFO_WID,
   parameter int GF_SIZE_LOG2  = DEF_GF_SIZE_LOG2,
   parameter int PCM_COLN      = DEF_PCM_COLN,
   parameter int IN_SYMS       = DEF_IN_SYMS
) (
   input  logic                                              clk,
   input  logic                                              rst_n,
   input  logic [IN_SYMS*INIT_INFO_WID-1:0]                  i_sym_data,
   input  logic                                              i_sym_valid,
   output logic                                              o_sym_ready,
   input  logic                                              i_sym_last,
   output logic [blk_size_f(GF_SIZE_LOG2)*INIT_INFO_WID-1:0] o_init_info,
   output logic                                              o_init_info_valid,
   input  logic                                              i_init_info_ready,
   output logic                                              o_init_info_last,
   output logic                                              o_len_err
);

   localparam int BLK_SIZE = blk_size_f(GF_SIZE_LOG2);
   localparam int BLK_W    = BLK_SIZE * INIT_INFO_WID;
   localparam int CNT_W    = clog2_f(PCM_COLN);
   localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(PCM_COLN - 1);

   logic             accept;
   logic             load;
   logic             len_err;
   logic             space;
   logic             avail;
   logic [BLK_W-1:0] blk;
   logic [CNT_W-1:0] blk_cnt;

   assign o_sym_ready = space;
   assign accept      = i_sym_valid && space;
   // A length error discards the beat in flight, so it must not also load a block.
   assign load        = avail && (!o_init_info_valid || i_init_info_ready) && !len_err;

`ifdef INIT_PACK_LEN_CHK_EN
   localparam int FRAME_SYMS = frame_syms_f(PCM_COLN, GF_SIZE_LOG2);
   localparam int SCNT_W     = clog2_f(FRAME_SYMS + IN_SYMS);
   localparam logic [SCNT_W-1:0] FRAME_CNT = SCNT_W'(FRAME_SYMS);
   localparam logic [SCNT_W-1:0] IN_CNT    = SCNT_W'(IN_SYMS);

   logic [SCNT_W-1:0] sym_cnt;
   logic [SCNT_W-1:0] sym_sum;
   logic              frame_done;

   assign sym_sum    = sym_cnt + IN_CNT;
   assign frame_done = (sym_sum >= FRAME_CNT);
   assign len_err    = accept && (i_sym_last != frame_done);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_cnt   <= '0;
         o_len_err <= 1'b0;
      end else begin
         o_len_err <= len_err;
         if (len_err) begin
            sym_cnt <= '0;
         end else if (accept) begin
            sym_cnt <= frame_done ? (sym_sum - FRAME_CNT) : sym_sum;
         end
      end
   end
`else
   logic unused_last;
   assign unused_last = i_sym_last;
   assign len_err     = 1'b0;
   assign o_len_err   = 1'b0;
`endif

   init_info_packer_sym_accum #(
      .SYM_WID  (INIT_INFO_WID),
      .BLK_SIZE (BLK_SIZE),
      .IN_SYMS  (IN_SYMS)
   ) u_sym_accum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (len_err),
      .push  (accept),
      .pop   (load),
      .data  (i_sym_data),
      .space (space),
      .avail (avail),
      .blk   (blk)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_init_info       <= '0;
         o_init_info_valid <= 1'b0;
         o_init_info_last  <= 1'b0;
         blk_cnt           <= '0;
      end else begin
         if (load) begin
            o_init_info       <= blk;
            o_init_info_valid <= 1'b1;
            o_init_info_last  <= (blk_cnt == LAST_BLK);
            blk_cnt           <= (blk_cnt == LAST_BLK) ? '0 : (blk_cnt + CNT_W'(1));
         end else if (i_init_info_ready) begin
            o_init_info_valid <= 1'b0;
         end
         if (len_err) begin
            blk_cnt <= '0;
         end
      end
   end

endmodule

// File: doc/init_info_packer.md
INIT_INFO_PACKER -- requirements
Module: init_info_packer

Interface
REQ-001 SHALL have parameter INIT_INFO_WID, default 2: bits per init-info symbol.
REQ-002 SHALL have parameter GF_SIZE_LOG2, default 7: BLK_SIZE = 2^GF_SIZE_LOG2-1 = 127 symbols per block.
REQ-003 SHALL have parameter PCM_COLN, default 72: blocks per frame.
REQ-004 SHALL have parameter IN_SYMS, default 8: symbols per input beat, 1..BLK_SIZE.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_sym_data, input, IN_SYMS*INIT_INFO_WID: symbol k at bits [k*INIT_INFO_WID +: INIT_INFO_WID].
REQ-008 SHALL have ports i_sym_valid (input, 1), o_sym_ready (output, 1), i_sym_last (input, 1, final beat of frame).
REQ-009 SHALL have port o_init_info, output, BLK_SIZE*INIT_INFO_WID: one block to decoder.
REQ-010 SHALL have ports o_init_info_valid (output, 1), i_init_info_ready (input, 1, from decoder o_init_info_ready).
REQ-011 SHALL have ports o_init_info_last (output, 1, block PCM_COLN-1 of frame) and o_len_err (output, 1, one-cycle pulse).

Function
REQ-012 Input beat accepted iff i_sym_valid && o_sym_ready; output block transferred iff o_init_info_valid && i_init_info_ready.
REQ-013 Accepted symbols SHALL append, in arrival order, to an accumulator of BLK_SIZE+IN_SYMS-1 symbols with fill counter; first-arrived symbol occupies block bits [INIT_INFO_WID-1:0].
REQ-014 o_sym_ready SHALL equal (fill < BLK_SIZE), combinational from registered fill only.
REQ-015 When fill >= BLK_SIZE and output register empty or transferring this cycle, lowest BLK_SIZE symbols SHALL load into o_init_info next cycle; remainder shifts down, fill -= BLK_SIZE (plus any simultaneous IN_SYMS append).
REQ-016 Latency: block whose last symbol arrives in beat N SHALL present o_init_info_valid at cycle N+1 when output register free.
REQ-017 o_init_info and o_init_info_last SHALL hold stable while valid && !ready; valid SHALL not drop without transfer.
REQ-018 Block counter (clog2(PCM_COLN) bits) SHALL increment per loaded block, wrap PCM_COLN-1 -> 0; o_init_info_last set on block PCM_COLN-1.
REQ-019 Full throughput: simultaneous accept, load and transfer in one cycle SHALL sustain one beat per cycle whenever the decoder is ready.
REQ-020 Blocks straddling beats (BLK_SIZE not multiple of IN_SYMS) SHALL be assembled without symbol loss or reorder.

Reset
REQ-021 rst_n low SHALL asynchronously clear fill, block counter, accumulator, o_init_info=0, o_init_info_valid=0, o_init_info_last=0, o_len_err=0; o_sym_ready=1 after release.
REQ-022 Reset mid-frame SHALL discard all partial data; next accepted symbol is symbol 0 of block 0.

Configuration
REQ-023 With INIT_PACK_LEN_CHK_EN defined: if i_sym_last is accepted on a beat other than the one completing symbol PCM_COLN*BLK_SIZE-1 (or that symbol completes without i_sym_last), o_len_err SHALL pulse one cycle, accumulator and block counter clear, pending output block still completes.
REQ-024 Without INIT_PACK_LEN_CHK_EN: i_sym_last ignored, framing by count only, o_len_err tied 0.

Structure
REQ-025 Shared package SHALL hold BLK_SIZE derivation, clog2 function and frame symbol count PCM_COLN*BLK_SIZE.
REQ-026 Sub-module sym_accum (accumulator + fill counter + shift) is natural; output register and block counter stay in top.

Verification
REQ-027 1143 beats of all-zero symbols, ready=1 -> 72 blocks, o_init_info_last only on 72nd, o_sym_ready never low more than 1 cycle per block.
REQ-028 Symbol value = index mod 4 -> block 1 bits[1:0] = 127 mod 4 = 3 (beat 15 symbol 7), all 9144 symbols in order.
REQ-029 i_init_info_ready low 20 cycles at block 5 -> o_init_info stable, o_sym_ready low once fill >= 127, no data loss.
REQ-030 rst_n pulsed after beat 500 -> outputs zero immediately, next frame's block 0 correct.
REQ-031 INIT_PACK_LEN_CHK_EN, i_sym_last on beat 1000 -> o_len_err one pulse, next beat is symbol 0 of block 0; undefined -> no pulse.
